// File: rtl/pipe_pkg.sv
// Shared types and default constants for the two-entry pipeline stage.
package pipe_pkg;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultCntW  = 16;

    // Encoding equals the number of beats held.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with clock enable and asynchronous reset to RESET_VAL.
module pipe_data_reg #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage: registered valid/ready, in-order delivery,
// synchronous flush and a saturating back-pressure counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH     = DefaultWidth,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned      CNT_W     = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [WIDTH-1:0] main_d, skid_q;
    logic             main_en, skid_en, main_from_skid;
    logic             in_xfer, out_xfer;

    // Handshake outputs depend on registered state only.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            StBusy: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            StFull: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: ;
        endcase
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_en = 1'b1;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_xfer && out_xfer) begin
                        main_en = 1'b1;
                    end else if (in_xfer) begin
                        skid_en = 1'b1;
                        state_d = StFull;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_en        = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = StBusy;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk  (clk),
        .rst  (rst),
        .en_i (main_en),
        .d_i  (main_d),
        .q_o  (out_data)
    );

    pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .en_i (skid_en),
        .d_i  (in_data),
        .q_o  (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios then random traffic, checked every cycle
// against a queue-based reference model.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready, flush;
    logic [31:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occupancy;
    logic [1:0]  s_stall_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [31:0] mq[$];
    int unsigned stall_m;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(
        .WIDTH (32),
        .CNT_W (2)
    ) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (s_in_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .occupancy (s_occupancy),
        .stall_cnt (s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    task automatic check_all();
        check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        check("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        if (mq.size() > 0) check("out_data", out_data, mq[0]);
        check("stall_cnt", 32'(stall_cnt), sat(stall_m, 65535));
        check("sat_stall_cnt", 32'(s_stall_cnt), sat(stall_m, 3));
        check("sat_occupancy", 32'(s_occupancy), 32'(mq.size()));
    endtask

    // Advance one clock; model applies the rules to the inputs seen at that edge.
    task automatic cycle();
        bit nonempty, has_room;
        @(posedge clk);
        #1;
        nonempty = mq.size() > 0;
        has_room = mq.size() < 2;
        if (flush) begin
            mq.delete();
        end else begin
            if (nonempty && !out_ready) stall_m++;
            if (nonempty && out_ready) void'(mq.pop_front());
            if (in_valid && has_room) mq.push_back(in_data);
        end
        check_all();
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic ordy,
                         input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        mq.delete();
        stall_m = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        stall_m = 0;
        #1;
        check("reset_out_data", out_data, 32'h0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming with out_ready held high.
        drive(1'b1, 32'h11, 1'b1, 1'b0); cycle();
        check("stream_0x11", out_data, 32'h11);
        drive(1'b1, 32'h22, 1'b1, 1'b0); cycle();
        check("stream_0x22", out_data, 32'h22);
        drive(1'b1, 32'h33, 1'b1, 1'b0); cycle();
        check("stream_0x33", out_data, 32'h33);
        check("stream_occ", 32'(occupancy), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
        check("stream_stall", 32'(stall_cnt), 32'd0);

        // Back-pressure: third beat must be refused.
        do_reset();
        drive(1'b1, 32'hA1, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hA2, 1'b0, 1'b0); cycle();
        check("bp_full_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 32'hA3, 1'b0, 1'b0); cycle();
        check("bp_occ", 32'(occupancy), 32'd2);
        check("bp_head", out_data, 32'hA1);
        drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
        check("bp_second", out_data, 32'hA2);
        cycle();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_stall", 32'(stall_cnt), 32'd2);

        // Flush while full with a beat offered.
        drive(1'b1, 32'hB1, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hB2, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'hFF, 1'b0, 1'b1); cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_occ", 32'(occupancy), 32'd0);
        check("flush_stall", 32'(stall_cnt), 32'd3);
        drive(1'b0, 32'h0, 1'b1, 1'b0); cycle();
        check("flush_no_ff", 32'(out_valid), 32'd0);

        // Saturation on the narrow counter.
        do_reset();
        drive(1'b1, 32'hC1, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle();
        check("sat_reaches_3", 32'(s_stall_cnt), 32'd3);
        check("wide_counts_6", 32'(stall_cnt), 32'd6);

        // Asynchronous reset mid-FULL, checked before any clock edge.
        drive(1'b1, 32'hD1, 1'b0, 1'b0); cycle();
        check("pre_reset_full", 32'(occupancy), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_sat_valid", 32'(s_out_valid), 32'd0);
        do_reset();

        // Random traffic against the reference queue.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 63) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width in bits (1..256).
REQ-002 SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into both data registers on reset.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width in bits (>=2).
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-005 SHALL have in_valid  in  1  upstream beat present.
REQ-006 SHALL have in_data  in  WIDTH  upstream payload.
REQ-007 SHALL have in_ready  out  1  stage can accept a beat this cycle.
REQ-008 SHALL have out_valid  out  1  downstream beat present.
REQ-009 SHALL have out_data  out  WIDTH  downstream payload.
REQ-010 SHALL have out_ready  in  1  downstream accepts this cycle.
REQ-011 SHALL have flush  in  1  synchronous discard of all held beats.
REQ-012 SHALL have occupancy  out  2  beats held (0..2).
REQ-013 SHALL have stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-014 SHALL define an input transfer as in_valid & in_ready at a rising edge, and an output transfer as out_valid & out_ready.
REQ-015 SHALL hold at most two beats in a main register (drives out_data) and a skid register.
REQ-016 SHALL use states EMPTY (0 beats), BUSY (main full), FULL (main and skid full); occupancy = 0/1/2 respectively.
REQ-017 SHALL drive in_ready = (state != FULL) and out_valid = (state != EMPTY), both decoded from registered state only (no combinational in-to-out path).
REQ-018 EMPTY: on input transfer, main <= in_data, go BUSY; otherwise stay.
REQ-019 BUSY: input and output transfer together -> main <= in_data, stay BUSY; input only -> skid <= in_data, go FULL; output only -> go EMPTY; neither -> stay.
REQ-020 FULL: on output transfer, main <= skid, go BUSY; otherwise stay; in_data ignored.
REQ-021 SHALL deliver a beat accepted into EMPTY on out_data in the next cycle (latency 1); beats SHALL leave in acceptance order, none duplicated or lost.
REQ-022 SHALL, with flush high at an edge, go EMPTY regardless of other inputs; any beat offered in that cycle SHALL be dropped; data register contents are don't-care afterward.
REQ-023 SHALL keep out_data stable while out_valid & !out_ready.
REQ-024 SHALL increment stall_cnt each cycle with out_valid & !out_ready & !flush, saturating at 2^CNT_W-1 (no wrap).
REQ-025 SHALL not change stall_cnt on flush; only rst clears it.

Reset
REQ-026 SHALL on rst, immediately and independent of clk: state EMPTY, in_ready 1, out_valid 0, occupancy 0, stall_cnt 0, out_data RESET_VAL, skid RESET_VAL.
REQ-027 SHALL discard any held beats when rst asserts mid-operation; first transfer possible at the first rising edge after rst deasserts.

Structure
REQ-028 SHALL place the state enumeration (EMPTY/BUSY/FULL) and default WIDTH/CNT_W constants in shared package pipe_pkg.
REQ-029 SHALL implement main and skid registers as two instances of sub-module pipe_data_reg (WIDTH-bit register, clock enable, async active-high reset to RESET_VAL).

Verification
REQ-030 Reset: assert rst mid-FULL -> immediately out_valid 0, in_ready 1, occupancy 0, out_data 0x00000000, stall_cnt 0.
REQ-031 Streaming: out_ready held 1, push 0x11,0x22,0x33 on consecutive cycles -> each appears one cycle later in order, occupancy stays 1, stall_cnt 0.
REQ-032 Back-pressure: out_ready 0, push 0xA1,0xA2,0xA3 -> FULL after 2 beats, in_ready 0, 0xA3 not accepted; release out_ready -> 0xA1 then 0xA2 delivered, stall_cnt equals stalled cycles.
REQ-033 Flush: in FULL, assert flush with in_valid 1, in_data 0xFF -> next cycle out_valid 0, occupancy 0, 0xFF never delivered, stall_cnt unchanged.
REQ-034 Saturation: CNT_W=2, out_ready 0 for 6 cycles with one beat held -> stall_cnt reaches 3 and stays 3.
REQ-035 Random: random in_valid/out_ready/flush over 10000 cycles against a 2-deep reference queue -> order, no loss/duplication, occupancy match every cycle.
